dist_sqrt_arbiter: RTL and testbench

- Shares the single CORDIC square-root core between NREQ tour-distance requesters, such as parallel annealing workers evaluating candidate swaps.
- Arbitrates squared-distance requests round-robin and drives the core's input.
- Tracks in-flight requests in an in-order tag FIFO and routes each root back to the requester that issued it.
- Sits between the distance datapaths and cordic_sqrt; replaces the direct sqrt hookup in the top level.

---
 rtl/dist_sqrt_arbiter_pkg.sv | 30 +++
 rtl/dist_sqrt_arbiter_sync_tag_fifo.sv | 46 ++++
 rtl/dist_sqrt_arbiter.sv | 108 ++++++++++
 tb/tb_dist_sqrt_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dist_sqrt_arbiter_pkg.sv
// tsp_arb_pkg: shared widths, FSM state type and round-robin helpers for dist_sqrt_arbiter
//   tag_w(n)   tag width $clog2(n) (min 1) -> TAG_W
//   cnt_w(d)   in-flight counter width $clog2(d)+1 -> CNT_W
//   state_t    {RUN, DRAIN}
//   onehot(i)  8-bit one-hot of a 3-bit index
//   rr_pick    {found, index} of first set bit of v at or above ptr, modulo n
package tsp_arb_pkg;
  localparam int MAX_NREQ = 8;
  typedef enum logic {RUN, DRAIN} state_t;
  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int d);
    return $clog2(d) + 1;
  endfunction
  function automatic logic [MAX_NREQ-1:0] onehot(input logic [2:0] i);
    return MAX_NREQ'(1) << i;
  endfunction
  function automatic logic [3:0] rr_pick(input logic [MAX_NREQ-1:0] v, input logic [2:0] ptr, input int n);
    logic [3:0] r;
    logic [2:0] idx;
    r = '0;
    // walk downward so the smallest offset from ptr is the last one written
    for (int k = MAX_NREQ - 1; k >= 0; k--) begin
      idx = 3'((int'(ptr) + k) % n);
      if (k < n && v[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction
endpackage

// File: rtl/dist_sqrt_arbiter_sync_tag_fifo.sv
// sync_tag_fifo: synchronous in-order FIFO of requester tags
//   clk, rst         clock, sync active-high reset
//   push, din        write din when not full
//   pop, dout        dout is the head entry; pop removes it when not empty
//   count, full, empty  occupancy status
module sync_tag_fifo #(
  parameter int W = 2,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr, rd;
  always_comb begin
    full = count == CW'(DEPTH);
    empty = count == '0;
    wr = push && !full;
    rd = pop && !empty;
    dout = mem[rd_ptr];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (rd) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(wr) - CW'(rd);
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/dist_sqrt_arbiter.sv
// dist_sqrt_arbiter: round-robin sharing of one in-order sqrt core among NREQ requesters
//   clk, rst              clock, sync active-high reset
//   req_valid/req_data    per-requester squared distances (packed, PRECISION each)
//   req_ready             combinational one-hot grant
//   sqrt_inp_valid/_inp   registered drive of the core input
//   sqrt_out_valid/_out   core result
//   rsp_valid/rsp_data    one-hot result strobe and shared result bus
//   drain_req, idle       stop granting / drained indication
//   protocol_err          sticky: core result arrived with nothing in flight
//   SQRT_ARB_STATS_EN adds stats_grants (16-bit saturating per requester) and stats_hwm
module dist_sqrt_arbiter
  import tsp_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PRECISION = 32,
  parameter int OUT_W = 24,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*PRECISION-1:0] req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      sqrt_inp_valid,
  output logic [PRECISION-1:0]      sqrt_inp,
  input  logic                      sqrt_out_valid,
  input  logic [OUT_W-1:0]          sqrt_out,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [OUT_W-1:0]          rsp_data,
  input  logic                      drain_req,
  output logic                      idle,
  output logic                      protocol_err
`ifdef SQRT_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]                   stats_grants,
  output logic [cnt_w(MAX_INFLIGHT)-1:0]       stats_hwm
`endif
);
  localparam int TAG_W = tag_w(NREQ);
  localparam int CNT_W = cnt_w(MAX_INFLIGHT);
  state_t state;
  logic [TAG_W-1:0] rr_ptr, tag;
  logic [CNT_W-1:0] count;
  logic [3:0] pick;
  logic [2:0] g;
  logic [MAX_NREQ-1:0] oh_g, oh_t;
  logic [PRECISION-1:0] sel;
  logic found, grant, pop, full, empty;
  always_comb begin
    pick = rr_pick(MAX_NREQ'(req_valid), 3'(rr_ptr), NREQ);
    found = pick[3];
    g = pick[2:0];
    // full is the registered occupancy, so a same-cycle pop cannot open a slot
    grant = !rst && state == RUN && !full && found;
    oh_g = onehot(g);
    oh_t = onehot(3'(tag));
    req_ready = grant ? oh_g[NREQ-1:0] : '0;
    pop = sqrt_out_valid && !empty;
    sel = req_data[int'(g)*PRECISION +: PRECISION];
  end
  sync_tag_fifo #(.W(TAG_W), .DEPTH(MAX_INFLIGHT)) u_tags (
    .clk(clk),
    .rst(rst),
    .push(grant),
    .din(g[TAG_W-1:0]),
    .pop(pop),
    .dout(tag),
    .count(count),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      rr_ptr <= '0;
      sqrt_inp_valid <= 1'b0;
      sqrt_inp <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
      idle <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      state <= drain_req ? DRAIN : RUN;
      idle <= state == DRAIN && count == '0;
      sqrt_inp_valid <= grant;
      if (grant) begin
        sqrt_inp <= sel;
        rr_ptr <= (int'(g) == NREQ - 1) ? '0 : TAG_W'(g + 3'd1);
      end
      rsp_valid <= pop ? oh_t[NREQ-1:0] : '0;
      if (pop) rsp_data <= sqrt_out;
      if (sqrt_out_valid && empty) protocol_err <= 1'b1;
    end
  end
`ifdef SQRT_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stats_grants <= '0;
      stats_hwm <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (req_ready[i] && stats_grants[i*16 +: 16] != 16'hffff)
          stats_grants[i*16 +: 16] <= stats_grants[i*16 +: 16] + 16'd1;
      if (count > stats_hwm) stats_hwm <= count;
    end
  end
`endif
endmodule

// File: tb/tb_dist_sqrt_arbiter.sv
// tb_dist_sqrt_arbiter: randomized scoreboard bench for dist_sqrt_arbiter with an in-order core model
module tb_dist_sqrt_arbiter;
  localparam int N = 4;
  localparam int P = 32;
  localparam int OW = 24;
  localparam int MI = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N*P-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic sqrt_inp_valid;
  logic [P-1:0] sqrt_inp;
  logic sqrt_out_valid = 1'b0;
  logic [OW-1:0] sqrt_out = '0;
  logic [N-1:0] rsp_valid;
  logic [OW-1:0] rsp_data;
  logic drain_req = 1'b0;
  logic idle;
  logic protocol_err;
  always #5 clk = ~clk;
  dist_sqrt_arbiter #(.NREQ(N), .PRECISION(P), .OUT_W(OW), .MAX_INFLIGHT(MI)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .sqrt_inp_valid(sqrt_inp_valid),
    .sqrt_inp(sqrt_inp),
    .sqrt_out_valid(sqrt_out_valid),
    .sqrt_out(sqrt_out),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .drain_req(drain_req),
    .idle(idle),
    .protocol_err(protocol_err)
  );
  typedef struct {int tag; longint root;} rsp_t;
  typedef struct {int due; longint val;} core_t;
  rsp_t rsp_q[$];
  rsp_t rsp_due[$];
  longint inp_q[$];
  core_t pipe[$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int lat = 12;
  bit k_rst = 1, k_drain = 0, k_stall = 0, k_inject = 0, k_fixed = 1;
  int k_pv = 100;
  int m_count = 0, m_rr = 0;
  bit m_drain = 0, m_idle = 0, m_err = 0;
  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask
  function automatic longint isqrt(input longint x);
    longint r, t;
    r = 0;
    for (int b = 20; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction
  always @(negedge clk) begin : monitor
    longint e;
    rsp_t r;
    if (inp_q.size() > 0) begin
      e = inp_q.pop_front();
      check("inp_valid", sqrt_inp_valid, 1);
      check("inp_data", sqrt_inp, e);
    end else check("inp_valid", sqrt_inp_valid, 0);
    if (sqrt_inp_valid) pipe.push_back('{cyc + lat, isqrt(longint'(sqrt_inp))});
    if (rsp_due.size() > 0) begin
      r = rsp_due.pop_front();
      check("rsp_valid", rsp_valid, longint'(1) << r.tag);
      check("rsp_data", rsp_data, r.root);
    end else check("rsp_valid", rsp_valid, 0);
  end
  task automatic step();
    bit cv;
    longint cval, r;
    longint data [N];
    longint roots [N];
    logic [N-1:0] v;
    core_t ce;
    int g;
    @(negedge clk);
    #1;
    check("idle", idle, m_idle);
    check("protocol_err", protocol_err, m_err);
    cv = 0;
    cval = 0;
    if (k_inject) begin
      cv = 1;
      cval = $urandom_range(0, 1000);
    end else if (!k_stall && !k_rst && pipe.size() > 0 && pipe[0].due <= cyc) begin
      ce = pipe.pop_front();
      cv = 1;
      cval = ce.val;
    end
    if (k_rst) pipe.delete();
    for (int i = 0; i < N; i++) begin
      v[i] = $urandom_range(0, 99) < k_pv;
      if (k_fixed) r = i + 3;
      else r = $urandom_range(0, 65535);
      roots[i] = r;
      data[i] = k_fixed ? r * r : r * r + $urandom_range(0, int'(2 * r));
      req_data[i*P +: P] = data[i][P-1:0];
    end
    rst = k_rst;
    drain_req = k_drain;
    req_valid = v;
    sqrt_out_valid = cv;
    sqrt_out = cval[OW-1:0];
    #1;
    g = -1;
    if (!k_rst && !m_drain && m_count < MI)
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(m_rr + k) % N]) g = (m_rr + k) % N;
    check("req_ready", req_ready, (g < 0) ? 0 : (longint'(1) << g));
    if (k_rst) begin
      m_count = 0;
      m_rr = 0;
      m_drain = 0;
      m_idle = 0;
      m_err = 0;
      rsp_q.delete();
    end else begin
      m_idle = m_drain && m_count == 0;
      if (cv && m_count == 0) m_err = 1;
      if (cv && m_count > 0) begin
        rsp_due.push_back(rsp_q.pop_front());
        m_count--;
      end
      if (g >= 0) begin
        inp_q.push_back(data[g]);
        rsp_q.push_back('{g, roots[g]});
        m_count++;
        m_rr = (g + 1) % N;
      end
      m_drain = k_drain;
    end
    cyc++;
  endtask
  initial begin
    repeat (4) step();
    check("rst_sqrt_inp", sqrt_inp, 0);
    check("rst_rsp_data", rsp_data, 0);
    k_rst = 0;
    repeat (100) step();
    k_fixed = 0;
    k_pv = 40;
    repeat (200) step();
    k_pv = 100;
    k_stall = 1;
    repeat (30) step();
    k_stall = 0;
    repeat (40) step();
    k_pv = 60;
    repeat (20) step();
    k_pv = 100;
    k_drain = 1;
    repeat (40) step();
    k_drain = 0;
    repeat (30) step();
    k_drain = 1;
    repeat (40) step();
    k_inject = 1;
    step();
    k_inject = 0;
    repeat (5) step();
    k_drain = 0;
    repeat (30) step();
    k_rst = 1;
    repeat (20) step();
    check("midrst_sqrt_inp", sqrt_inp, 0);
    check("midrst_rsp_data", rsp_data, 0);
    k_rst = 0;
    k_pv = 70;
    repeat (60) step();
    k_pv = 0;
    repeat (40) step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1);
  end
endmodule
